cook_timer_ctrl: RTL
====================

Name: cook_timer_ctrl

Overview:
- Sequencing controller for the 3-digit down-counting minutes/seconds timer (mins, sec_tens, sec_ones; `zero` flag).
- Accepts keypad digits and shifts them into the timer via its serial digit load: each load shifts mins<=sec_tens, sec_tens<=sec_ones, sec_ones<=data.
- Generates the once-per-second count enable, handles start/stop/door events, and flags completion.
- Sits between the front-panel key decoder and the timer, sharing the timer's clock.

Parameters:
- TICK_DIV, 50000000, clock cycles per one-second enable pulse (minimum 2).
- MAX_DIGITS, 3, maximum digits accepted per entry; further digits are ignored.

Ports:
- clock  in  1  system clock, all state updates on rising edge.
- clrn  in  1  asynchronous active-low reset.
- key_valid  in  1  single-cycle pulse: digit key pressed.
- key_digit  in  4  BCD digit, valid with key_valid; values >9 ignored.
- start_p  in  1  single-cycle start pulse.
- stop_p  in  1  single-cycle stop/clear pulse.
- door_closed  in  1  level, 1 = door closed.
- zero  in  1  timer all-digits-zero flag.
- data  out  4  digit to timer load input.
- loadn  out  1  active-low one-cycle load strobe to timer.
- tmr_clrn  out  1  active-low one-cycle clear strobe to timer.
- enable  out  1  one-cycle count-down enable to timer.
- mag_on  out  1  load active (high only in RUN).
- done  out  1  high in DONE.
- state_o  out  3  current state encoding for debug.

Behaviour:
- All outputs registered. Reset (clrn=0, asynchronous) puts the block in IDLE with data=0, loadn=1, tmr_clrn=1, enable=0, mag_on=0, done=0, digit count=0, prescaler=0.
- States: IDLE=0, ENTRY=1, RUN=2, PAUSE=3, DONE=4.
- Event priority when several arrive in the same cycle: stop_p > door opening > start_p > key_valid.
- IDLE, digit: key_valid with key_digit<=9 -> next cycle loadn=0, data=key_digit (exactly one cycle); count=1; go to ENTRY.
- ENTRY, digit: same load action if count<MAX_DIGITS, then count++. If count==MAX_DIGITS, the key is ignored (no strobe).
- Data hold: data keeps its last value when loadn=1.
- Start: start_p in IDLE/ENTRY/PAUSE with door_closed=1 and zero=0 -> RUN. Otherwise ignored (state unchanged).
- Prescaler on start: reset to 0 when entering RUN from IDLE/ENTRY; retained when resuming from PAUSE.
- RUN: prescaler increments each cycle. When it reaches TICK_DIV-1, it wraps to 0 and enable=1 for that one cycle. mag_on=1.
- Zero in RUN: zero=1 sampled -> DONE next cycle. enable is suppressed in the cycle zero=1 is seen, so the timer never wraps below 0:00.
- RUN pause events: door_closed=0 or stop_p -> PAUSE (mag_on=0 next cycle, prescaler held).
- PAUSE: stop_p -> tmr_clrn=0 one cycle, count=0, go to IDLE. start_p resumes only if door_closed=1.
- Stop elsewhere: in IDLE/ENTRY/DONE, stop_p -> tmr_clrn=0 one cycle, count=0, go to IDLE.
- DONE: done=1, mag_on=0. Any key_valid, start_p, or door opening -> IDLE. The timer is not cleared on this exit, but count resets to 0. A digit pressed in DONE is consumed by the exit and not loaded.
- Strobe exclusivity: loadn, tmr_clrn and enable are never simultaneously active.
- Asynchronous reset mid-RUN returns to IDLE immediately. Timer contents are the timer's concern (it shares clrn).

Test Plan:
- Reset: assert clrn=0 mid-run -> loadn=1, tmr_clrn=1, enable=0, mag_on=0, done=0, state_o=0 immediately.
- Entry: TICK_DIV=4; keys 1,3,0 then 7 -> exactly three loadn pulses with data 1,3,0, each one cycle after key_valid; the key 7 is ignored; timer reads 1:30.
- Countdown: TICK_DIV=4, timer at 0:03, start_p -> enable pulses 4 cycles apart; 3 pulses total; done=1 one cycle after zero=1; no 4th pulse.
- Door: open door 2 cycles after an enable in RUN -> PAUSE, mag_on=0, no enables; close and start_p -> first enable after the remaining 2 cycles (prescaler retained).
- Gating: start_p with zero=1, or with door_closed=0 -> state stays IDLE/ENTRY, mag_on stays 0; simultaneous start_p+stop_p in ENTRY -> tmr_clrn pulse, IDLE.
- Stop/exit: stop_p in PAUSE -> tmr_clrn low one cycle, IDLE, count=0. key_valid in DONE -> IDLE, no loadn pulse.

Source files
------------

// File: rtl/cook_timer_ctrl.sv
// Sequencing controller for a 3-digit mm:ss down-counting timer.
// Shifts keypad digits into the timer, paces the count with a 1 s enable, and tracks run/pause/done.
module cook_timer_ctrl #(
  parameter int TICK_DIV   = 50000000,
  parameter int MAX_DIGITS = 3
) (
  input  logic       clock,
  input  logic       clrn,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       start_p,
  input  logic       stop_p,
  input  logic       door_closed,
  input  logic       zero,
  output logic [3:0] data,
  output logic       loadn,
  output logic       tmr_clrn,
  output logic       enable,
  output logic       mag_on,
  output logic       done,
  output logic [2:0] state_o
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] COUNT_MAX  = CW'(MAX_DIGITS);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ENTRY = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    data_q, data_d;
  logic          loadn_q, loadn_d;
  logic          tmr_clrn_q, tmr_clrn_d;
  logic          enable_q, enable_d;
  logic          mag_on_q, mag_on_d;
  logic          done_q, done_d;

  logic digit_ok;
  logic can_start;

  assign digit_ok  = key_valid && (key_digit <= 4'd9);
  assign can_start = start_p && door_closed && !zero;

  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      presc_q    <= '0;
      data_q     <= 4'd0;
      loadn_q    <= 1'b1;
      tmr_clrn_q <= 1'b1;
      enable_q   <= 1'b0;
      mag_on_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      presc_q    <= presc_d;
      data_q     <= data_d;
      loadn_q    <= loadn_d;
      tmr_clrn_q <= tmr_clrn_d;
      enable_q   <= enable_d;
      mag_on_q   <= mag_on_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    presc_d    = presc_q;
    data_d     = data_q;
    loadn_d    = 1'b1;
    tmr_clrn_d = 1'b1;
    enable_d   = 1'b0;

    case (state_q)
      ST_IDLE, ST_ENTRY: begin
        // A start pulse owns its cycle even when gated off, so a coincident digit is dropped.
        if (stop_p) begin
          tmr_clrn_d = 1'b0;
          count_d    = '0;
          state_d    = ST_IDLE;
        end else if (start_p) begin
          if (can_start) begin
            state_d = ST_RUN;
            presc_d = '0;
          end
        end else if (digit_ok && (count_q < COUNT_MAX)) begin
          loadn_d = 1'b0;
          data_d  = key_digit;
          count_d = count_q + 1'b1;
          state_d = ST_ENTRY;
        end
      end

      ST_RUN: begin
        if (stop_p || !door_closed) begin
          state_d = ST_PAUSE;
        end else if (zero) begin
          // No enable on this cycle: the timer must not wrap below 0:00.
          state_d = ST_DONE;
        end else if (presc_q == PRESC_LAST) begin
          presc_d  = '0;
          enable_d = 1'b1;
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end

      ST_PAUSE: begin
        if (stop_p) begin
          tmr_clrn_d = 1'b0;
          count_d    = '0;
          state_d    = ST_IDLE;
        end else if (can_start) begin
          state_d = ST_RUN;
        end
      end

      ST_DONE: begin
        if (stop_p) begin
          tmr_clrn_d = 1'b0;
          count_d    = '0;
          state_d    = ST_IDLE;
        end else if (key_valid || start_p || !door_closed) begin
          count_d = '0;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        count_d = '0;
      end
    endcase

    mag_on_d = (state_d == ST_RUN);
    done_d   = (state_d == ST_DONE);
  end

  assign data     = data_q;
  assign loadn    = loadn_q;
  assign tmr_clrn = tmr_clrn_q;
  assign enable   = enable_q;
  assign mag_on   = mag_on_q;
  assign done     = done_q;
  assign state_o  = state_q;

endmodule
